// File: rtl/branch_target_unit.sv
// Registered branch/jump target computation with a small fully-associative BTB.
// One request per cycle in; the result carries the prediction made at acceptance and a mispredict flag.
module branch_target_unit #(
  parameter int PC_W      = 32,
  parameter int IMM_W     = 16,
  parameter int SHIFT     = 2,
  parameter int BTB_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_jump,
  input  logic             req_taken,
  input  logic [PC_W-1:0]  req_pc,
  input  logic [IMM_W-1:0] req_imm,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [PC_W-1:0]  res_target,
  output logic             res_taken,
  output logic [PC_W-1:0]  res_next_pc,
  output logic [PC_W-1:0]  res_pred_pc,
  output logic             res_mispredict
);

  localparam int PTR_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = PC_W - SHIFT;

  logic             res_valid_q, res_valid_d;
  logic [PC_W-1:0]  res_target_q, res_target_d;
  logic             res_taken_q, res_taken_d;
  logic [PC_W-1:0]  res_next_pc_q, res_next_pc_d;
  logic [PC_W-1:0]  res_pred_pc_q, res_pred_pc_d;
  logic             res_mispredict_q, res_mispredict_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;

  logic             btb_valid_q [BTB_DEPTH];
  logic             btb_valid_d [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag_q   [BTB_DEPTH];
  logic [TAG_W-1:0] btb_tag_d   [BTB_DEPTH];
  logic [PC_W-1:0]  btb_tgt_q   [BTB_DEPTH];
  logic [PC_W-1:0]  btb_tgt_d   [BTB_DEPTH];
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;

  logic             accept;
  logic             res_fire;
  logic [PC_W-1:0]  pc4;
  logic [PC_W-1:0]  br_target;
  logic [PC_W-1:0]  jmp_target;
  logic [PC_W-1:0]  hi_mask;
  logic [PC_W-1:0]  req_target;
  logic             req_tkn;
  logic [PC_W-1:0]  req_next;
  logic [PC_W-1:0]  lk_pred;
  logic             up_hit;
  logic [PTR_W-1:0] up_idx;

  assign req_ready = !flush & (!res_valid_q | res_ready);
  assign accept    = req_valid & req_ready;
  // A flushed result is discarded, so it never trains the BTB.
  assign res_fire  = res_valid_q & res_ready & !flush;

  always_comb begin
    pc4        = req_pc + PC_W'(4);
    br_target  = pc4 + ({{(PC_W-IMM_W){req_imm[IMM_W-1]}}, req_imm} << SHIFT);
    hi_mask    = {PC_W{1'b1}} << (IMM_W + SHIFT);
    jmp_target = (pc4 & hi_mask) | (PC_W'(req_imm) << SHIFT);
    req_target = req_is_jump ? jmp_target : br_target;
    req_tkn    = req_is_jump | req_taken;
    req_next   = req_tkn ? req_target : pc4;
  end

  // Lookup sees only the registered BTB, so a same-edge update is invisible to it.
  always_comb begin
    lk_pred = pc4;
    for (int i = 0; i < BTB_DEPTH; i++) begin
      if (btb_valid_q[i] && (btb_tag_q[i] == req_pc[PC_W-1:SHIFT])) begin
        lk_pred = btb_tgt_q[i];
      end
    end
  end

  always_comb begin
    up_hit = 1'b0;
    up_idx = '0;
    for (int i = 0; i < BTB_DEPTH; i++) begin
      if (btb_valid_q[i] && (btb_tag_q[i] == res_tag_q)) begin
        up_hit = 1'b1;
        up_idx = PTR_W'(i);
      end
    end
  end

  always_comb begin
    res_valid_d      = res_valid_q;
    res_target_d     = res_target_q;
    res_taken_d      = res_taken_q;
    res_next_pc_d    = res_next_pc_q;
    res_pred_pc_d    = res_pred_pc_q;
    res_mispredict_d = res_mispredict_q;
    res_tag_d        = res_tag_q;
    if (flush) begin
      res_valid_d = 1'b0;
    end else if (accept) begin
      res_valid_d = 1'b1;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
    if (accept) begin
      res_target_d     = req_target;
      res_taken_d      = req_tkn;
      res_next_pc_d    = req_next;
      res_pred_pc_d    = lk_pred;
      res_mispredict_d = (req_next != lk_pred);
      res_tag_d        = req_pc[PC_W-1:SHIFT];
    end
  end

  always_comb begin
    btb_valid_d = btb_valid_q;
    btb_tag_d   = btb_tag_q;
    btb_tgt_d   = btb_tgt_q;
    rr_ptr_d    = rr_ptr_q;
    if (res_fire) begin
      if (res_taken_q) begin
        if (up_hit) begin
          btb_tgt_d[up_idx] = res_target_q;
        end else begin
          btb_valid_d[rr_ptr_q] = 1'b1;
          btb_tag_d[rr_ptr_q]   = res_tag_q;
          btb_tgt_d[rr_ptr_q]   = res_target_q;
          rr_ptr_d              = rr_ptr_q + PTR_W'(1);
        end
      end else if (up_hit) begin
        btb_valid_d[up_idx] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid_q      <= 1'b0;
      res_target_q     <= '0;
      res_taken_q      <= 1'b0;
      res_next_pc_q    <= '0;
      res_pred_pc_q    <= '0;
      res_mispredict_q <= 1'b0;
      res_tag_q        <= '0;
      rr_ptr_q         <= '0;
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_valid_q[i] <= 1'b0;
        btb_tag_q[i]   <= '0;
        btb_tgt_q[i]   <= '0;
      end
    end else begin
      res_valid_q      <= res_valid_d;
      res_target_q     <= res_target_d;
      res_taken_q      <= res_taken_d;
      res_next_pc_q    <= res_next_pc_d;
      res_pred_pc_q    <= res_pred_pc_d;
      res_mispredict_q <= res_mispredict_d;
      res_tag_q        <= res_tag_d;
      rr_ptr_q         <= rr_ptr_d;
      btb_valid_q      <= btb_valid_d;
      btb_tag_q        <= btb_tag_d;
      btb_tgt_q        <= btb_tgt_d;
    end
  end

  assign res_valid      = res_valid_q;
  assign res_target     = res_target_q;
  assign res_taken      = res_taken_q;
  assign res_next_pc    = res_next_pc_q;
  assign res_pred_pc    = res_pred_pc_q;
  assign res_mispredict = res_mispredict_q;

endmodule

// File: doc/branch_target_unit.md
# branch_target_unit

Parametrised, registered successor to the combinational branch/jump address logic. Accepts one resolved control-flow instruction per cycle over a valid/ready handshake and computes the branch or jump target and the actual next PC. It also keeps a small fully-associative branch target buffer (BTB), so each result carries the predicted next PC and a mispredict flag. Sits between the execute stage and fetch redirect logic.

## Interface
- PC_W, 32, PC/address width in bits
- IMM_W, 16, immediate field width
- SHIFT, 2, immediate left-shift (word alignment)
- BTB_DEPTH, 4, BTB entries (power of 2, ≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  discard the in-flight result; block acceptance this cycle
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_is_jump  in  1  1 = unconditional jump, 0 = conditional branch
- req_taken  in  1  resolved branch condition (ignored when req_is_jump=1)
- req_pc  in  PC_W  PC of the instruction
- req_imm  in  IMM_W  immediate field
- res_valid  out  1  result register holds a result
- res_ready  in  1  consumer accepts the result
- res_target  out  PC_W  computed target address
- res_taken  out  1  req_is_jump | req_taken
- res_next_pc  out  PC_W  res_taken ? res_target : pc+4
- res_pred_pc  out  PC_W  BTB prediction captured at acceptance
- res_mispredict  out  1  res_next_pc != res_pred_pc

## Operation
- All arithmetic is modulo 2^PC_W. pc4 = req_pc + 4.
- Branch target: pc4 + (sign-extended req_imm << SHIFT).
- Jump target: {pc4[PC_W-1:IMM_W+SHIFT], req_imm, SHIFT zeros}.
- BTB entry: valid bit, tag = pc[PC_W-1:SHIFT], target (PC_W). Round-robin replacement pointer rr_ptr, log2(BTB_DEPTH) bits.
- Lookup happens at request acceptance, against req_pc. Hit: pred = entry target. Miss: pred = pc4.
- BTB update happens at the result handshake (res_valid & res_ready). It does not happen on a flushed result.
  - Taken, hit: overwrite target in place; rr_ptr unchanged.
  - Taken, miss: write entry[rr_ptr], set valid; rr_ptr = rr_ptr+1, wrapping BTB_DEPTH-1 → 0.
  - Not taken, hit: clear that entry's valid bit.
  - Not taken, miss: no change.
- Tags are unique: at most one matching valid entry.
- Flush clears res_valid at the next edge. It does not touch BTB contents or rr_ptr.

## Timing
- Single pipeline stage, latency 1. A request accepted at edge N is visible on res_* after edge N.
- req_ready = !flush & (!res_valid | res_ready), combinational. This gives full throughput, one result per cycle, when the consumer is always ready.
- While res_valid=1 and res_ready=0, all res_* outputs hold stable.
- The BTB write from the handshake at edge N is not visible to a lookup accepted at the same edge N; it is visible from edge N+1 on.
- Flush and res_ready in the same cycle: flush wins. There is no BTB update and res_valid becomes 0.
- Reset (asserted asynchronously at any time, including mid-handshake):
  - res_valid=0, all res_* data outputs 0.
  - All BTB valid bits 0, rr_ptr=0.
  - req_ready=1 once rst_n is high.

## Test plan
- Reset: hold a result with res_ready=0, then pulse rst_n low mid-cycle → res_valid=0 immediately, all res_* = 0. A following taken branch at pc=0x100 mispredicts, confirming the BTB is empty.
- Branch and predictor: taken branch, pc=0x100, imm=0x0003 → target=0x110, next_pc=0x110, pred=0x104, mispredict=1. Repeat the same request → pred=0x110, mispredict=0. Repeat with taken=0 → next_pc=0x104, mispredict=1. Repeat again → entry invalidated, pred=0x104.
- Sign and wrap arithmetic:
  - pc=0x100, imm=0xFFFF, taken → target=0x100.
  - pc=0xFFFF_FFFC, imm=0x0000, taken → target=0x0000_0000.
- Jump: pc=0x1000_0004, imm=0x000A, is_jump=1, taken=0 → target=0x1000_0028, res_taken=1.
- Backpressure and flush:
  - Stall with res_ready=0 for 3 cycles → req_ready=0, res_* stable.
  - Assert flush together with res_ready → res_valid=0 next cycle, and a repeat request shows no BTB update from the flushed result.
  - Back-to-back requests with res_ready=1 → one result per cycle.
- BTB full: BTB_DEPTH=4. Taken branches at pc=0x100, 0x200, 0x300, 0x400, 0x500 (imm=1) → rr_ptr wraps. pc=0x100 now misses (mispredict=1). pc=0x200 still hits (pred=0x208).
